// File: rtl/mips_dmem_responder_if.sv
// mips_dmem_responder_if: data bus between the MIPS core and the data-side
// responder, plus the outbound mailbox valid/ready port.
//   memwrite  : store strobe from core
//   aluout    : byte address from core
//   writedata : store data from core
//   readdata  : load data to core (combinational)
//   out_valid : mailbox head valid
//   out_data  : mailbox head word
//   out_ready : consumer accepts head
// Modports: slave = responder side, master = core/consumer side.
interface mips_dmem_responder_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport slave (
        input  memwrite,
        input  aluout,
        input  writedata,
        input  out_ready,
        output readdata,
        output out_valid,
        output out_data
    );

    modport master (
        output memwrite,
        output aluout,
        output writedata,
        output out_ready,
        input  readdata,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: data-side memory responder for the single-cycle MIPS
// core. Word-addressed RAM at 0x0xxxxxxx plus an I/O page:
//   0xFFFF0000 CNT  : free-running cycle counter (read / load)
//   0xFFFF0004 MBOX : mailbox FIFO push (write) / head peek (read)
//   0xFFFF0008 STAT : {occupancy[8:4], overflow[2], empty[1], full[0]}
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mips_dmem_responder_if.slave (core data bus + mailbox port)
// Optional feature: define MIPS_DMEM_TIMER_EN to instantiate the counter;
// otherwise CNT reads return 0 and CNT writes are ignored.
module mips_dmem_responder #(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_dmem_responder_if.slave   bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [29:0] CNT_WADDR  = 30'h3FFF_C000;
    localparam logic [29:0] MBOX_WADDR = 30'h3FFF_C001;
    localparam logic [29:0] STAT_WADDR = 30'h3FFF_C002;

    // Address decode on the word address
    logic          sel_ram, sel_cnt, sel_mbox, sel_stat;
    logic [AW-1:0] ram_idx;
    logic          unused_addr_bits;

    assign sel_ram          = (bus.aluout[31:28] == 4'h0);
    assign sel_cnt          = (bus.aluout[31:2] == CNT_WADDR);
    assign sel_mbox         = (bus.aluout[31:2] == MBOX_WADDR);
    assign sel_stat         = (bus.aluout[31:2] == STAT_WADDR);
    assign ram_idx          = bus.aluout[AW+1:2];
    assign unused_addr_bits = ^bus.aluout[1:0];

    // Data RAM: no reset, contents persist across reset
    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (bus.memwrite && sel_ram) begin
            mem[ram_idx] <= bus.writedata;
        end
    end

    // Cycle counter
    logic [31:0] cnt_rd;
`ifdef MIPS_DMEM_TIMER_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bus.memwrite && sel_cnt) begin
            cnt_q <= bus.writedata;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_rd = cnt_q;
`else
    assign cnt_rd = '0;
`endif

    // Mailbox FIFO state
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_req, push, pop, full, empty, ovf_clr;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && bus.out_ready;
    assign push_req = bus.memwrite && sel_mbox;
    // A full FIFO still accepts a push when the head leaves the same cycle
    assign push     = push_req && (!full || pop);
    assign ovf_clr  = bus.memwrite && sel_stat && bus.writedata[2];

    // Next-state for pointers, occupancy and sticky overflow
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // Set takes priority over clear
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates its visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.writedata;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = fifo_mem[rd_ptr_q];

    logic [31:0] stat_word;
    assign stat_word = {23'd0, 5'(count_q), 1'b0, ovf_q, empty, full};

    // Combinational load path
    always_comb begin
        bus.readdata = '0;
        if (sel_ram) begin
            bus.readdata = mem[ram_idx];
        end else if (sel_cnt) begin
            bus.readdata = cnt_rd;
        end else if (sel_mbox) begin
            bus.readdata = empty ? 32'd0 : fifo_mem[rd_ptr_q];
        end else if (sel_stat) begin
            bus.readdata = stat_word;
        end
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: directed self-checking bench for mips_dmem_responder
// (MEM_WORDS = 64, FIFO_DEPTH = 8). Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_mips_dmem_responder;
    localparam logic [31:0] CNT_A  = 32'hFFFF_0000;
    localparam logic [31:0] MBOX_A = 32'hFFFF_0004;
    localparam logic [31:0] STAT_A = 32'hFFFF_0008;
`ifdef MIPS_DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_dmem_responder_if bus ();

    mips_dmem_responder #(
        .MEM_WORDS  (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Store that spans one rising edge; returns on the next falling edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.aluout    = addr;
        bus.writedata = data;
        bus.memwrite  = 1'b1;
        @(negedge clk);
        bus.memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.aluout = addr;
        #1;
        data = bus.readdata;
    endtask

    logic [31:0] d;
    logic [31:0] exp_q [8];

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.memwrite  = 1'b0;
        bus.aluout    = '0;
        bus.writedata = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rd(STAT_A, d); check("rst_stat", d, 32'h2);
        rd(CNT_A, d);  check("rst_cnt", d, 32'd0);

        // Counter: release on a falling edge, read before the 5th rising edge
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        rd(CNT_A, d); check("cnt_edge5", d, TIMER ? 32'd4 : 32'd0);
        wr(CNT_A, 32'hFFFF_FFFE);
        rd(CNT_A, d); check("cnt_load", d, TIMER ? 32'hFFFF_FFFE : 32'd0);
        @(negedge clk);
        rd(CNT_A, d); check("cnt_max", d, TIMER ? 32'hFFFF_FFFF : 32'd0);
        @(negedge clk);
        rd(CNT_A, d); check("cnt_wrap", d, 32'd0);

        // RAM and unmapped space
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, d); check("ram_rd", d, 32'hDEAD_BEEF);
        rd(32'h0000_0013, d); check("ram_rd_lowbits", d, 32'hDEAD_BEEF);
        wr(32'h0000_0000, 32'h1111_1111);
        rd(32'h0000_0400, d); check("ram_alias", d, 32'h1111_1111);
        rd(32'h2000_0000, d); check("unmapped_rd", d, 32'd0);
        wr(32'hFFFF_000C, 32'h1234_5678);
        rd(32'hFFFF_000C, d); check("unmapped_wr", d, 32'd0);

        // Mailbox fill and overflow
        check("mbox_idle_valid", 32'(bus.out_valid), 32'd0);
        rd(MBOX_A, d); check("mbox_empty_rd", d, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            wr(MBOX_A, 32'(i));
            if (i == 1) begin
                #1;
                check("push_valid", 32'(bus.out_valid), 32'd1);
            end
        end
        rd(STAT_A, d);  check("stat_full_ovf", d, 32'h85);
        rd(MBOX_A, d);  check("mbox_head", d, 32'd1);
        wr(STAT_A, 32'h4);
        rd(STAT_A, d);  check("stat_ovf_clr", d, 32'h81);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_data", bus.out_data, 32'(i));
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        rd(STAT_A, d); check("stat_drained", d, 32'h2);
        check("drained_valid", 32'(bus.out_valid), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 1; i <= 8; i++) begin
            wr(MBOX_A, 32'(i));
        end
        rd(STAT_A, d); check("stat_refill", d, 32'h81);
        bus.out_ready = 1'b1;
        wr(MBOX_A, 32'hA5);
        bus.out_ready = 1'b0;
        rd(STAT_A, d); check("stat_pushpop", d, 32'h81);
        for (int i = 0; i < 7; i++) begin
            exp_q[i] = 32'(i + 2);
        end
        exp_q[7] = 32'hA5;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("pp_drain", bus.out_data, exp_q[i]);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        rd(STAT_A, d); check("stat_pp_empty", d, 32'h2);

        // Asynchronous reset mid-operation
        wr(CNT_A, 32'd97);
        wr(MBOX_A, 32'h100);
        wr(MBOX_A, 32'h101);
        wr(MBOX_A, 32'h102);
        rd(STAT_A, d); check("stat_three", d, 32'h30);
        rd(CNT_A, d);  check("cnt_100", d, TIMER ? 32'd100 : 32'd0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        rd(STAT_A, d); check("async_rst_stat", d, 32'h2);
        rd(CNT_A, d);  check("async_rst_cnt", d, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(32'h0000_0010, d); check("ram_keep_10", d, 32'hDEAD_BEEF);
        rd(32'h0000_0000, d); check("ram_keep_0", d, 32'h1111_1111);
        @(negedge clk);
        rd(CNT_A, d); check("cnt_after_rst", d, TIMER ? 32'd1 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
